// File: rtl/stop_watch_disp_pkg.sv
// -----------------------------------------------------------------------------
// stop_watch_disp_pkg
// Shared types and seven-segment constants for the stopwatch display mux.
// Segment patterns are active-low, bit order g,f,e,d,c,b,a (bit 6..0).
// sseg_t carries dp in bit 7 followed by the seven segments.
// -----------------------------------------------------------------------------
package stop_watch_disp_pkg;

   typedef logic [7:0] sseg_t;   // {dp, g, f, e, d, c, b, a}, active-low
   typedef logic [1:0] pos_t;    // display position index, 0 = rightmost

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam sseg_t      SSEG_BLANK = 8'hFF;

   // Active-low one-hot digit enable for a shown position.
   function automatic logic [3:0] pos_an(input pos_t p);
      logic [3:0] a;
      a = 4'b1111;
      a[p] = 1'b0;
      return a;
   endfunction

endpackage

// File: rtl/stop_watch_disp_mux_bcd_to_sseg.sv
// -----------------------------------------------------------------------------
// bcd_to_sseg
// Combinational BCD to seven-segment decoder (active-low, g..a).
// Values 10..15 are not valid BCD and show a dash.
// Ports:
//   bcd  in  [3:0]  digit value
//   seg  out [6:0]  segment pattern g,f,e,d,c,b,a
// -----------------------------------------------------------------------------
module bcd_to_sseg
   import stop_watch_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stop_watch_disp_mux.sv
// -----------------------------------------------------------------------------
// stop_watch_disp_mux
// Time-multiplexes three BCD stopwatch digits (10 s, 1 s, 0.1 s) onto a
// 4-position common-anode seven-segment display. Position 3 is always blank,
// the decimal point is lit on position 1 (between seconds and tenths).
// Digits are snapshotted once per frame so a frame never shows a torn value.
//
// Parameters:
//   N        refresh counter width (3..24); each position lasts 2^(N-2) clocks
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   d2,d1,d0 BCD digits for 10 s, 1 s, 0.1 s
//   an       active-low digit enables, bit k = position k (0 rightmost)
//   sseg     active-low {dp,g,f,e,d,c,b,a}, registered (1-cycle latency)
// Build options:
//   SWD_LZ_BLANK_EN  when defined, position 2 is blanked while its digit is 0
// -----------------------------------------------------------------------------
module stop_watch_disp_mux
   import stop_watch_disp_pkg::*;
#(
   parameter int N = 18
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] d2,
   input  logic [3:0] d1,
   input  logic [3:0] d0,
   output logic [3:0] an,
   output sseg_t      sseg
);

   logic [N-1:0] cnt;
   logic [3:0]   s2, s1, s0;
   pos_t         sel;
   logic [3:0]   dig;
   logic [6:0]   seg;
   logic         blank;
   logic         dp_n;
   logic [3:0]   an_nxt;
   sseg_t        sseg_nxt;

   assign sel = pos_t'(cnt[N-1:N-2]);

   // Refresh counter and per-frame snapshot. Loading on the last count of the
   // frame means the new value becomes visible exactly at sel=0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         s2  <= '0;
         s1  <= '0;
         s0  <= '0;
      end else begin
         cnt <= cnt + 1'b1;
         if (&cnt) begin
            s2 <= d2;
            s1 <= d1;
            s0 <= d0;
         end
      end
   end

   always_comb begin
      dig   = s0;
      blank = 1'b0;
      dp_n  = 1'b1;
      case (sel)
         2'd0: dig = s0;
         2'd1: begin
            dig  = s1;
            dp_n = 1'b0;
         end
         2'd2: begin
            dig = s2;
`ifdef SWD_LZ_BLANK_EN
            blank = (s2 == 4'd0);
`else
            blank = 1'b0;
`endif
         end
         default: blank = 1'b1;
      endcase
   end

   // Single decoder shared by all positions, fed by the selected snapshot.
   bcd_to_sseg u_dec (
      .bcd (dig),
      .seg (seg)
   );

   always_comb begin
      an_nxt   = blank ? 4'b1111 : pos_an(sel);
      sseg_nxt = blank ? SSEG_BLANK : {dp_n, seg};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         an   <= 4'b1111;
         sseg <= SSEG_BLANK;
      end else begin
         an   <= an_nxt;
         sseg <= sseg_nxt;
      end
   end

endmodule

// File: tb/tb_stop_watch_disp_mux.sv
// -----------------------------------------------------------------------------
// tb_stop_watch_disp_mux
// Directed bench for stop_watch_disp_mux at N=4 (16-cycle frame). A cycle
// model predicts {an,sseg} before each rising edge and queues it; the DUT
// output is popped and compared on the following falling edge.
// Honors SWD_LZ_BLANK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_stop_watch_disp_mux;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] d2, d1, d0;
   logic [3:0] an;
   logic [7:0] sseg;

   int total = 0;
   int bad   = 0;
   logic [11:0] q[$];
   logic [3:0]  mcnt;
   logic [3:0]  m2, m1, m0;

   always #5 clk = ~clk;

   stop_watch_disp_mux #(.N(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .d2      (d2),
      .d1      (d1),
      .d0      (d0),
      .an      (an),
      .sseg    (sseg)
   );

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Expected {an,sseg} after the next edge, from pre-edge model state.
   function automatic logic [11:0] model();
      case (mcnt[3:2])
         2'd0: return {4'b1110, 1'b1, ref_seg(m0)};
         2'd1: return {4'b1101, 1'b0, ref_seg(m1)};
         2'd2: begin
`ifdef SWD_LZ_BLANK_EN
            if (m2 == 4'd0) return 12'hFFF;
`endif
            return {4'b1011, 1'b1, ref_seg(m2)};
         end
         default: return 12'hFFF;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs an=%b sseg=%b exp an=%b sseg=%b",
                tag, obs[11:8], obs[7:0], exp[11:8], exp[7:0]);
      end
   endtask

   task automatic step(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         q.push_back(model());
         @(posedge clk);
         if (mcnt == 4'hF) {m2, m1, m0} = {d2, d1, d0};
         mcnt = mcnt + 4'd1;
         @(negedge clk);
         chk(tag, {an, sseg}, q.pop_front());
      end
   endtask

   task automatic model_reset();
      mcnt = 4'd0;
      {m2, m1, m0} = 12'h000;
   endtask

   initial begin
      reset_n = 1'b0;
      d2 = 4'd9; d1 = 4'd8; d0 = 4'd7;
      model_reset();

      // Held in reset with live inputs and running clock.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 chk("reset_hold", {an, sseg}, 12'hFFF);
         d2 = 4'($urandom_range(15)); d1 = 4'($urandom_range(15)); d0 = 4'($urandom_range(15));
      end

      // Release with 1,2,3: frame 1 shows zeros, frame 2 shows 1,2.3.
      @(negedge clk);
      d2 = 4'd1; d1 = 4'd2; d0 = 4'd3;
      reset_n = 1'b1;
      model_reset();
      step(1, "first_after_reset");
      chk("first_pos0_zero", {an, sseg}, {4'b1110, 8'b11000000});
      step(31, "frames_123");

      // Mid-frame change of d0 must wait for the next snapshot.
      step(5, "pre_change");
      d0 = 4'd7;
      step(27, "d0_change");
      step(1, "d0_new_frame");
      chk("d0_shows_7", {an, sseg}, {4'b1110, 8'b11111000});
      step(15, "d0_tail");

      // Invalid digit decodes to dash, with dp on position 1.
      d1 = 4'd12;
      step(21, "dash");
      chk("dash_dp", {an, sseg}, {4'b1101, 8'b00111111});
      step(11, "dash_tail");

      // Leading zero case.
      d2 = 4'd0; d1 = 4'd5; d0 = 4'd0;
      step(25, "lead_zero");
`ifdef SWD_LZ_BLANK_EN
      chk("lz_pos2", {an, sseg}, 12'hFFF);
`else
      chk("lz_pos2", {an, sseg}, {4'b1011, 8'b11000000});
`endif
      step(7, "lead_zero_tail");

      // Reset asserted while sel=2.
      d2 = 4'd4; d1 = 4'd6; d0 = 4'd8;
      step(16, "pre_mid_reset");
      while (mcnt[3:2] != 2'd2) step(1, "to_sel2");
      step(1, "at_sel2");
      reset_n = 1'b0;
      #1 chk("mid_reset_async", {an, sseg}, 12'hFFF);
      @(posedge clk);
      #1 chk("mid_reset_hold", {an, sseg}, 12'hFFF);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      step(1, "restart");
      chk("restart_an", {8'h00, an}, {8'h00, 4'b1110});
      step(31, "restart_tail");

      // Random digits, including non-BCD, changed at arbitrary points.
      for (int i = 0; i < 12; i++) begin
         d2 = 4'($urandom_range(15));
         d1 = 4'($urandom_range(15));
         d0 = 4'($urandom_range(15));
         step(int'($urandom_range(3, 9)), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
